dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, power of two; the word capacity of the backing store.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, range 0..15; the wait states inserted before each response.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port mem_req, input, 1 bit: the initiator requests an access.
REQ-006 SHALL have port mem_we, input, 1 bit: 1 is a write, 0 is a read.
REQ-007 SHALL have port mem_addr, input, 32 bits: the byte address.
REQ-008 SHALL have port mem_wmask, input, 4 bits: byte-lane enables (bit n covers bits 8n+7..8n).
REQ-009 SHALL have port mem_wdata, input, 32 bits: write data, already lane-aligned.
REQ-010 SHALL have port mem_ready, output, 1 bit: the responder can accept a request.
REQ-011 SHALL have port mem_rvalid, output, 1 bit: a one-cycle completion pulse for reads and writes.
REQ-012 SHALL have port mem_rdata, output, 32 bits: the full aligned read word.
REQ-013 SHALL have port mem_err, output, 1 bit: an error flag that qualifies mem_rvalid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP; mem_ready SHALL be 1 only in IDLE.
REQ-015 SHALL accept a request when mem_req and mem_ready are both 1, registering mem_we, mem_addr, mem_wmask and mem_wdata on that edge.
REQ-016 SHALL ignore mem_req outside IDLE; the initiator holds its request until it is accepted.
REQ-017 SHALL move from IDLE to WAIT on accept, loading a 4-bit wait counter with WAIT_CYCLES.
REQ-018 SHALL move from IDLE straight to RESP when WAIT_CYCLES is 0.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and enter RESP on the cycle after the counter reaches 1.
REQ-020 SHALL, in RESP, assert mem_rvalid for exactly one cycle and then return to IDLE.
REQ-021 SHALL give accept-to-rvalid latency of WAIT_CYCLES+1 cycles, and a minimum request spacing of WAIT_CYCLES+2 cycles.
REQ-022 SHALL index words with mem_addr[log2(DEPTH_WORDS)+1:2] and ignore mem_addr[1:0].
REQ-023 SHALL, for a write, update only the lanes enabled in mem_wmask, at the edge that enters RESP.
REQ-024 SHALL leave all lanes unchanged for a write with mem_wmask 0, and still acknowledge it with mem_rvalid.
REQ-025 SHALL, for a read, present the stored word on mem_rdata with mem_rvalid and ignore mem_wmask.
REQ-026 SHALL hold mem_rdata at its last read value, including across writes.
REQ-027 SHALL, for a read in the cycle immediately after a write to the same word, return the newly written data.

Reset
REQ-028 SHALL, while rst_n is 0, force state IDLE, wait counter 0, mem_rvalid 0, mem_rdata 0 and mem_err 0; mem_ready SHALL read 1 after reset.
REQ-029 SHALL abandon any in-flight access when reset asserts, with no memory write and no mem_rvalid.
REQ-030 SHALL NOT reset the contents of the backing store.

Configuration
REQ-031 SHALL, with DMEM_RANGE_CHECK_EN defined, treat an access as out of range when mem_addr bits 31..log2(DEPTH_WORDS)+2 are nonzero.
REQ-032 SHALL, for an out-of-range access, suppress the write, force mem_rdata to 0, and pulse mem_err together with mem_rvalid.
REQ-033 SHALL, with DMEM_RANGE_CHECK_EN undefined, ignore the upper address bits (aliasing wraps) and tie mem_err to 0.

Structure
REQ-034 SHALL place the FSM state enumeration, the 4-bit wait-counter width and the lane-count constant (4) in shared package dmem_pkg.
REQ-035 SHALL use one sub-module, dmem_bank: a DEPTH_WORDS x 32 synchronous RAM with 4 byte-write enables.

Verification
REQ-036 SHALL cover, with WAIT_CYCLES=1: write 0xDEADBEEF to 0x10 with mask 1111, then read 0x10 -> mem_rvalid 2 cycles after each accept, rdata 0xDEADBEEF.
REQ-037 SHALL cover: over 0xDEADBEEF at 0x10, write wdata 0x00AA0000 with mask 0100 to 0x12, then read -> 0xDEAABEEF.
REQ-038 SHALL cover: mem_req held high continuously -> mem_ready low in WAIT and RESP, and exactly one rvalid per accepted request.
REQ-039 SHALL cover: rst_n dropped during WAIT of a write to 0x20 -> no rvalid, and 0x20 still holds its prior value.
REQ-040 SHALL cover, with WAIT_CYCLES=0: a read accepted at cycle N -> mem_rvalid at cycle N+1, mem_ready back to 1 at N+2.
REQ-041 SHALL cover, with DMEM_RANGE_CHECK_EN and DEPTH_WORDS=1024: write to 0x1000 -> mem_err=1 with rvalid, and word 0 is unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states and widths for the data-memory responder
package dmem_pkg;

    // Wait-state counter width (WAIT_CYCLES up to 15)
    localparam int CNT_W = 4;

    // Byte lanes per 32-bit word
    localparam int LANES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState;

endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: DEPTH_WORDS x 32 synchronous RAM with per-byte write enables
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wrEn,
    input  logic             rdEn,
    input  logic [AW-1:0]    addr,
    input  logic [LANES-1:0] wmask,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Lane-masked writes; the array itself is never reset
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int l = 0; l < LANES; l++) begin
                if (wmask[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
            end
        end
    end

    // Read register only loads on reads, so it holds across writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdata <= '0;
        else if (rdEn) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory responder over a byte-maskable RAM
// Optional feature: define DMEM_RANGE_CHECK_EN to flag accesses beyond DEPTH_WORDS with mem_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wmask,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmemState         state;
    logic [CNT_W-1:0] waitCnt;
    logic             reqWe;
    logic [31:0]      reqAddr;
    logic [LANES-1:0] reqMask;
    logic [31:0]      reqData;
    logic             rvalidReg;
    logic             errReg;
    logic             zeroRdata;
    logic             accept;
    logic             goResp;
    logic             curWe;
    logic [31:0]      curAddr;
    logic [LANES-1:0] curMask;
    logic [31:0]      curData;
    logic             outOfRange;
    logic [31:0]      bankRdata;
    logic             unusedAddr;

    assign mem_ready  = (state == IDLE);
    assign mem_rvalid = rvalidReg;
    assign mem_err    = errReg;
    assign mem_rdata  = zeroRdata ? 32'h0 : bankRdata;

    // Gating with rst_n keeps a held request from touching memory while in reset
    assign accept = rst_n && mem_req && mem_ready;

    // The access lands in memory on the edge that enters RESP
    assign goResp = (WAIT_CYCLES == 0) ? accept
                                       : (state == WAIT) && (waitCnt == CNT_W'(1));

    // With zero wait states the access happens on the accept edge, so use live inputs
    assign curWe   = (state == IDLE) ? mem_we    : reqWe;
    assign curAddr = (state == IDLE) ? mem_addr  : reqAddr;
    assign curMask = (state == IDLE) ? mem_wmask : reqMask;
    assign curData = (state == IDLE) ? mem_wdata : reqData;

`ifdef DMEM_RANGE_CHECK_EN
    assign outOfRange = |curAddr[31:AW+2];
`else
    assign outOfRange = 1'b0;
`endif

    assign unusedAddr = ^{curAddr[31:AW+2], curAddr[1:0]};

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) bank (
        .clk  (clk),
        .rst_n(rst_n),
        .wrEn (goResp && curWe && !outOfRange),
        .rdEn (goResp && !curWe),
        .addr (curAddr[AW+1:2]),
        .wmask(curMask),
        .wdata(curData),
        .rdata(bankRdata)
    );

    // Request capture, wait-state sequencing and registered response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            waitCnt   <= '0;
            reqWe     <= 1'b0;
            reqAddr   <= '0;
            reqMask   <= '0;
            reqData   <= '0;
            rvalidReg <= 1'b0;
            errReg    <= 1'b0;
            zeroRdata <= 1'b0;
        end else begin
            rvalidReg <= goResp;
            errReg    <= goResp && outOfRange;
            if (goResp && !curWe) zeroRdata <= outOfRange;
            case (state)
                IDLE: begin
                    if (accept) begin
                        reqWe   <= mem_we;
                        reqAddr <= mem_addr;
                        reqMask <= mem_wmask;
                        reqData <= mem_wdata;
                        waitCnt <= CNT_W'(WAIT_CYCLES);
                        state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - CNT_W'(1);
                    if (waitCnt == CNT_W'(1)) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of the responder with one and zero wait states
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr1 = '0, wdata1 = '0;
    logic [3:0]  mask1 = '0;
    logic        ready1, rvalid1, err1;
    logic [31:0] rdata1;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  mask0 = '0;
    logic        ready0, rvalid0, err0;
    logic [31:0] rdata0;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        er;
    logic [31:0] expWord0, expOorData;
    logic        expErr;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .mem_req(req1), .mem_we(we1), .mem_addr(addr1),
        .mem_wmask(mask1), .mem_wdata(wdata1), .mem_ready(ready1), .mem_rvalid(rvalid1),
        .mem_rdata(rdata1), .mem_err(err1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req(req0), .mem_we(we0), .mem_addr(addr0),
        .mem_wmask(mask0), .mem_wdata(wdata0), .mem_ready(ready0), .mem_rvalid(rvalid0),
        .mem_rdata(rdata0), .mem_err(err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One access on the WAIT_CYCLES=1 instance with per-cycle handshake checks
    task automatic access1(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wdata, output logic [31:0] rdOut, output logic erOut);
        check("w1_ready_idle", ready1, 1);
        req1 = 1'b1; we1 = we; addr1 = addr; mask1 = mask; wdata1 = wdata;
        step();
        req1 = 1'b0;
        check("w1_ready_wait", ready1, 0);
        check("w1_rvalid_wait", rvalid1, 0);
        step();
        check("w1_rvalid_resp", rvalid1, 1);
        check("w1_ready_resp", ready1, 0);
        rdOut = rdata1;
        erOut = err1;
        step();
        check("w1_rvalid_drop", rvalid1, 0);
        check("w1_ready_back", ready1, 1);
    endtask

    // One access on the WAIT_CYCLES=0 instance: rvalid the cycle after accept
    task automatic access0(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wdata, output logic [31:0] rdOut);
        check("w0_ready_idle", ready0, 1);
        req0 = 1'b1; we0 = we; addr0 = addr; mask0 = mask; wdata0 = wdata;
        step();
        req0 = 1'b0;
        check("w0_rvalid_n1", rvalid0, 1);
        check("w0_ready_n1", ready0, 0);
        rdOut = rdata0;
        step();
        check("w0_rvalid_n2", rvalid0, 0);
        check("w0_ready_n2", ready0, 1);
    endtask

    initial begin
`ifdef DMEM_RANGE_CHECK_EN
        expErr = 1'b1; expWord0 = 32'h0BADF00D; expOorData = 32'h0;
`else
        expErr = 1'b0; expWord0 = 32'h55555555; expOorData = 32'h55555555;
`endif
        step();
        step();
        check("rst_ready", ready1, 1);
        check("rst_rvalid", rvalid1, 0);
        check("rst_rdata", rdata1, 32'h0);
        check("rst_err", err1, 0);
        check("rst_ready0", ready0, 1);
        rst_n = 1'b1;
        step();

        access1(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er);
        check("full_write_err", er, 0);
        access1(1'b0, 32'h10, 4'b0000, 32'h0, rd, er);
        check("full_read", rd, 32'hDEADBEEF);

        access1(1'b1, 32'h12, 4'b0100, 32'h00AA0000, rd, er);
        access1(1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
        check("lane2_merge", rd, 32'hDEAABEEF);

        access1(1'b1, 32'h14, 4'b1111, 32'h01020304, rd, er);
        check("rdata_hold_over_write", rdata1, 32'hDEAABEEF);

        access1(1'b1, 32'h10, 4'b0000, 32'h12345678, rd, er);
        access1(1'b0, 32'h13, 4'b1010, 32'h0, rd, er);
        check("zero_mask_and_low_bits", rd, 32'hDEAABEEF);

        // Request held high across a write then a read of the same word
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; mask1 = 4'hF; wdata1 = 32'h11223344;
        step();
        check("held_ready_wait", ready1, 0);
        we1 = 1'b0;
        step();
        check("held_ready_resp", ready1, 0);
        check("held_rvalid_wr", rvalid1, 1);
        step();
        check("held_idle_ready", ready1, 1);
        check("held_idle_rvalid", rvalid1, 0);
        step();
        check("held_rd_ready_wait", ready1, 0);
        check("held_rd_rvalid_wait", rvalid1, 0);
        req1 = 1'b0;
        step();
        check("held_rd_rvalid", rvalid1, 1);
        check("raw_same_word", rdata1, 32'h11223344);
        step();
        check("held_rd_rvalid_drop", rvalid1, 0);

        // Reset dropped in WAIT of a write: abandoned, no rvalid, no write
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h20; mask1 = 4'hF; wdata1 = 32'hCAFEF00D;
        step();
        req1 = 1'b0;
        check("abort_in_wait", ready1, 0);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", ready1, 1);
        check("abort_rvalid", rvalid1, 0);
        step();
        check("abort_rvalid_later", rvalid1, 0);
        check("abort_rdata_reset", rdata1, 32'h0);
        rst_n = 1'b1;
        step();
        check("abort_rvalid_post", rvalid1, 0);
        access1(1'b0, 32'h20, 4'b0000, 32'h0, rd, er);
        check("abort_kept_old", rd, 32'h11223344);

        // Out-of-range (or aliased) access to 0x1000
        access1(1'b1, 32'h0, 4'hF, 32'h0BADF00D, rd, er);
        access1(1'b1, 32'h1000, 4'hF, 32'h55555555, rd, er);
        check("oor_write_err", er, expErr);
        access1(1'b0, 32'h0, 4'h0, 32'h0, rd, er);
        check("oor_word0", rd, expWord0);
        check("inrange_err", er, 0);
        access1(1'b0, 32'h1000, 4'h0, 32'h0, rd, er);
        check("oor_read_data", rd, expOorData);
        check("oor_read_err", er, expErr);

        // Zero wait states
        access0(1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, rd);
        access0(1'b0, 32'h0, 4'h0, 32'h0, rd);
        check("w0_read", rd, 32'hA5A5A5A5);
        access0(1'b1, 32'h1, 4'b0001, 32'h0000003C, rd);
        access0(1'b0, 32'h2, 4'h0, 32'h0, rd);
        check("w0_lane0", rd, 32'hA5A5A53C);
        check("w0_err", err0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
